input_pixel_packer: RTL and testbench

Front-end writer for the input pixel SRAM. It accepts a serial stream of 9-bit pixels under a valid/ready handshake and packs every LANES pixels into one wide word. It presents that word on `data` with a one-cycle `we` write strobe, which matches the input SRAM's 90-bit write port. It also tracks frame boundaries: it emits a done pulse per frame and flags malformed frames.

---
 rtl/input_pixel_packer_if.sv | 31 +++
 rtl/input_pixel_packer.sv | 97 +++++++++
 tb/tb_input_pixel_packer.sv | 344 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/input_pixel_packer_if.sv
// Pixel-stream and SRAM write-port bundle for the input pixel packer.
// master = pixel source / SRAM side, slave = packer.
interface input_pixel_packer_if #(
    parameter int unsigned PIX_W = 9,
    parameter int unsigned LANES = 10,
    parameter int unsigned WORDS = 10
);
    localparam int unsigned DW = LANES * PIX_W;
    localparam int unsigned WW = $clog2(WORDS);

    logic [PIX_W-1:0] pix_in;
    logic             pix_valid;
    logic             pix_last;
    logic             pix_ready;
    logic             out_stall;
    logic [DW-1:0]    data;
    logic             we;
    logic [WW-1:0]    word_idx;
    logic             frame_done;
    logic             frame_err;

    modport master (
        output pix_in, pix_valid, pix_last, out_stall,
        input  pix_ready, data, we, word_idx, frame_done, frame_err
    );

    modport slave (
        input  pix_in, pix_valid, pix_last, out_stall,
        output pix_ready, data, we, word_idx, frame_done, frame_err
    );
endinterface

// File: rtl/input_pixel_packer.sv
// Packs a serial 9-bit pixel stream into LANES-wide SRAM words with one held
// output word, frame tracking and malformed-frame flagging.
module input_pixel_packer #(
    parameter int unsigned PIX_W = 9,
    parameter int unsigned LANES = 10,
    parameter int unsigned WORDS = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input_pixel_packer_if.slave   bus
);
    localparam int unsigned DW = LANES * PIX_W;
    localparam int unsigned LW = $clog2(LANES);
    localparam int unsigned WW = $clog2(WORDS);

    logic [LANES-1:0][PIX_W-1:0] r_acc;
    logic [LW-1:0]               r_lane_cnt;
    logic [WW-1:0]               r_word_cnt;
    logic [DW-1:0]               r_data;
    logic [WW-1:0]               r_word_idx;
    logic                        r_pend;
    logic                        r_done;
    logic                        r_err;

    logic                        w_ready;
    logic                        w_we;
    logic                        w_xfer;
    logic                        w_last_lane;
    logic                        w_last_word;
    logic                        w_complete;
    logic                        w_close;
    logic                        w_err;
    logic [LANES-1:0][PIX_W-1:0] w_word;

    // A held word that cannot be written blocks the input entirely.
    assign w_ready     = !(r_pend && bus.out_stall);
    assign w_we        = r_pend && !bus.out_stall;
    assign w_xfer      = bus.pix_valid && w_ready;
    assign w_last_lane = (r_lane_cnt == LW'(LANES - 1));
    assign w_last_word = (r_word_cnt == WW'(WORDS - 1));
    assign w_complete  = w_xfer && (w_last_lane || bus.pix_last);
    assign w_close     = w_complete && (bus.pix_last || w_last_word);
    // Early last and missing last both disagree with the full-frame position.
    assign w_err       = bus.pix_last ^ (w_last_lane && w_last_word);

    // Completed word: accumulated lanes, current pixel, zeros above it.
    always_comb begin
        w_word = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (LW'(k) < r_lane_cnt) begin
                w_word[k] = r_acc[k];
            end else if (LW'(k) == r_lane_cnt) begin
                w_word[k] = bus.pix_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc      <= '0;
            r_lane_cnt <= '0;
            r_word_cnt <= '0;
            r_data     <= '0;
            r_word_idx <= '0;
            r_pend     <= 1'b0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
        end else begin
            if (w_complete) begin
                r_acc      <= '0;
                r_lane_cnt <= '0;
            end else if (w_xfer) begin
                r_acc[r_lane_cnt] <= bus.pix_in;
                r_lane_cnt        <= r_lane_cnt + LW'(1);
            end

            // Loading a new word takes priority over clearing the written one.
            if (w_complete) begin
                r_data     <= DW'(w_word);
                r_word_idx <= r_word_cnt;
                r_pend     <= 1'b1;
                r_done     <= w_close;
                r_err      <= w_close && w_err;
                r_word_cnt <= w_close ? '0 : r_word_cnt + WW'(1);
            end else if (w_we) begin
                r_pend <= 1'b0;
            end
        end
    end

    assign bus.pix_ready  = w_ready;
    assign bus.we         = w_we;
    assign bus.data       = r_data;
    assign bus.word_idx   = r_word_idx;
    assign bus.frame_done = w_we && r_done;
    assign bus.frame_err  = w_we && r_err;
endmodule

// File: tb/tb_input_pixel_packer.sv
// Directed self-checking bench for input_pixel_packer.
module tb_input_pixel_packer;
    localparam int unsigned PIX_W = 9;
    localparam int unsigned LANES = 10;
    localparam int unsigned WORDS = 10;
    localparam int unsigned DW    = LANES * PIX_W;
    localparam int unsigned WW    = $clog2(WORDS);

    typedef struct {
        logic [DW-1:0] data;
        logic [WW-1:0] idx;
        logic          done;
        logic          err;
        int            cyc;
    } ent_t;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   cyc;
    ent_t q[$];

    input_pixel_packer_if #(.PIX_W(PIX_W), .LANES(LANES), .WORDS(WORDS)) bus ();

    input_pixel_packer #(.PIX_W(PIX_W), .LANES(LANES), .WORDS(WORDS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every write strobe with its payload and cycle.
    always @(negedge clk) begin
        if (bus.we === 1'b1) begin
            ent_t e;
            e.data = bus.data;
            e.idx  = bus.word_idx;
            e.done = bus.frame_done;
            e.err  = bus.frame_err;
            e.cyc  = cyc;
            q.push_back(e);
        end
    end

    function automatic logic [DW-1:0] mkword(input int base, input int n);
        logic [DW-1:0] w;
        w = '0;
        for (int k = 0; k < n; k++) w[k*PIX_W +: PIX_W] = PIX_W'(base + k);
        return w;
    endfunction

    task automatic apply_reset();
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.pix_in    = '0;
        bus.out_stall = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Present one pixel and hold it until accepted; called just after a posedge.
    task automatic push(input int v, input logic last);
        logic rdy;
        int   guard;
        bus.pix_valid = 1'b1;
        bus.pix_in    = PIX_W'(v);
        bus.pix_last  = last;
        guard = 0;
        do begin
            @(negedge clk);
            rdy = bus.pix_ready;
            @(posedge clk);
            #1;
            guard++;
        end while (!rdy && guard < 30);
        if (!rdy) begin
            n_checks++;
            n_fail++;
            $display("FAIL push_timeout: pixel %0d not accepted within 30 cycles", v);
        end
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if (bus.data !== '0) begin n_fail++; $display("FAIL reset_data: got %h expected 0", bus.data); end
        n_checks++;
        if (bus.we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b expected 0", bus.we); end
        n_checks++;
        if (bus.word_idx !== '0) begin n_fail++; $display("FAIL reset_word_idx: got %0d expected 0", bus.word_idx); end
        n_checks++;
        if (bus.frame_done !== 1'b0 || bus.frame_err !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: got done=%b err=%b expected 0 0", bus.frame_done, bus.frame_err);
        end
        n_checks++;
        if (bus.pix_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b expected 1", bus.pix_ready); end
        @(posedge clk);
        #1;
    endtask

    task automatic test_clean_frame();
        apply_reset();
        q.delete();
        for (int i = 0; i < 100; i++) push(i, i == 99);
        @(negedge clk);
        n_checks++;
        if (bus.we !== 1'b1 || bus.frame_done !== 1'b1 || bus.frame_err !== 1'b0) begin
            n_fail++;
            $display("FAIL clean_latency: got we=%b done=%b err=%b expected 1 1 0", bus.we, bus.frame_done, bus.frame_err);
        end
        idle(3);
        n_checks++;
        if (q.size() != 10) begin
            n_fail++; $display("FAIL clean_count: got %0d writes expected 10", q.size());
        end else begin
            for (int w = 0; w < 10; w++) begin
                n_checks++;
                if (q[w].data !== mkword(10 * w, 10) || q[w].idx !== WW'(w)) begin
                    n_fail++;
                    $display("FAIL clean_word%0d: got idx=%0d data=%h expected idx=%0d data=%h",
                             w, q[w].idx, q[w].data, w, mkword(10 * w, 10));
                end
                n_checks++;
                if (q[w].done !== (w == 9) || q[w].err !== 1'b0) begin
                    n_fail++;
                    $display("FAIL clean_flags%0d: got done=%b err=%b expected %b 0", w, q[w].done, q[w].err, w == 9);
                end
                if (w > 0) begin
                    n_checks++;
                    if (q[w].cyc - q[w-1].cyc != 10) begin
                        n_fail++;
                        $display("FAIL clean_spacing%0d: got %0d cycles expected 10", w, q[w].cyc - q[w-1].cyc);
                    end
                end
            end
        end
    endtask

    task automatic test_early_last();
        apply_reset();
        q.delete();
        for (int i = 0; i < 23; i++) push(i, i == 22);
        for (int i = 0; i < 10; i++) push(200 + i, 1'b0);
        idle(3);
        n_checks++;
        if (q.size() != 4) begin
            n_fail++; $display("FAIL early_count: got %0d writes expected 4", q.size());
        end else begin
            n_checks++;
            if (q[2].data !== mkword(20, 3) || q[2].idx !== WW'(2)) begin
                n_fail++;
                $display("FAIL early_word2: got idx=%0d data=%h expected idx=2 data=%h", q[2].idx, q[2].data, mkword(20, 3));
            end
            n_checks++;
            if (q[2].done !== 1'b1 || q[2].err !== 1'b1 || q[1].done !== 1'b0) begin
                n_fail++;
                $display("FAIL early_flags: got done=%b err=%b prev_done=%b expected 1 1 0", q[2].done, q[2].err, q[1].done);
            end
            n_checks++;
            if (q[3].idx !== '0 || q[3].data !== mkword(200, 10) || q[3].done !== 1'b0) begin
                n_fail++;
                $display("FAIL early_next_frame: got idx=%0d done=%b data=%h expected idx=0 done=0 data=%h",
                         q[3].idx, q[3].done, q[3].data, mkword(200, 10));
            end
        end
    endtask

    task automatic test_missing_last();
        apply_reset();
        q.delete();
        for (int i = 0; i < 110; i++) push(i, 1'b0);
        idle(3);
        n_checks++;
        if (q.size() != 11) begin
            n_fail++; $display("FAIL missing_count: got %0d writes expected 11", q.size());
        end else begin
            n_checks++;
            if (q[9].done !== 1'b1 || q[9].err !== 1'b1 || q[9].idx !== WW'(9) || q[9].data !== mkword(90, 10)) begin
                n_fail++;
                $display("FAIL missing_close: got idx=%0d done=%b err=%b data=%h expected idx=9 1 1 data=%h",
                         q[9].idx, q[9].done, q[9].err, q[9].data, mkword(90, 10));
            end
            n_checks++;
            if (q[10].idx !== '0 || q[10].data !== mkword(100, 10) || q[10].done !== 1'b0 || q[10].err !== 1'b0) begin
                n_fail++;
                $display("FAIL missing_next: got idx=%0d done=%b err=%b data=%h expected idx=0 0 0 data=%h",
                         q[10].idx, q[10].done, q[10].err, q[10].data, mkword(100, 10));
            end
        end
    endtask

    task automatic test_backpressure();
        int rel;
        apply_reset();
        q.delete();
        for (int i = 0; i < 10; i++) push(i, 1'b0);
        bus.out_stall = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = PIX_W'(10);
        bus.pix_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_checks++;
            if (bus.we !== 1'b0 || bus.pix_ready !== 1'b0 || bus.data !== mkword(0, 10) || bus.word_idx !== '0) begin
                n_fail++;
                $display("FAIL stall_cycle%0d: got we=%b ready=%b idx=%0d data=%h expected 0 0 0 %h",
                         c, bus.we, bus.pix_ready, bus.word_idx, bus.data, mkword(0, 10));
            end
            @(posedge clk);
            #1;
        end
        bus.out_stall = 1'b0;
        rel = cyc;
        for (int i = 10; i < 20; i++) push(i, 1'b0);
        idle(3);
        n_checks++;
        if (q.size() != 2) begin
            n_fail++; $display("FAIL stall_count: got %0d writes expected 2", q.size());
        end else begin
            n_checks++;
            if (q[0].cyc != rel || q[0].data !== mkword(0, 10)) begin
                n_fail++; $display("FAIL stall_release: got cycle %0d expected %0d", q[0].cyc, rel);
            end
            n_checks++;
            if (q[1].data !== mkword(10, 10) || q[1].idx !== WW'(1)) begin
                n_fail++;
                $display("FAIL stall_word1: got idx=%0d data=%h expected idx=1 data=%h", q[1].idx, q[1].data, mkword(10, 10));
            end
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        q.delete();
        for (int i = 0; i < 10; i++) push(i, 1'b0);
        bus.out_stall = 1'b1;
        bus.pix_valid = 1'b1;
        bus.pix_in    = PIX_W'(10);
        bus.pix_last  = 1'b1;
        idle(2);
        bus.out_stall = 1'b0;
        push(10, 1'b1);
        idle(3);
        n_checks++;
        if (q.size() != 2) begin
            n_fail++; $display("FAIL b2b_count: got %0d writes expected 2", q.size());
        end else begin
            n_checks++;
            if (q[1].cyc != q[0].cyc + 1 || q[0].idx !== '0 || q[1].idx !== WW'(1)) begin
                n_fail++;
                $display("FAIL b2b_order: got cycles %0d,%0d idx %0d,%0d expected consecutive idx 0,1",
                         q[0].cyc, q[1].cyc, q[0].idx, q[1].idx);
            end
            n_checks++;
            if (q[0].data !== mkword(0, 10) || q[1].data !== mkword(10, 1)) begin
                n_fail++;
                $display("FAIL b2b_data: got %h,%h expected %h,%h", q[0].data, q[1].data, mkword(0, 10), mkword(10, 1));
            end
            n_checks++;
            if (q[0].done !== 1'b0 || q[1].done !== 1'b1 || q[1].err !== 1'b1) begin
                n_fail++;
                $display("FAIL b2b_flags: got done0=%b done1=%b err1=%b expected 0 1 1", q[0].done, q[1].done, q[1].err);
            end
        end
    endtask

    task automatic test_reset_mid_word();
        apply_reset();
        q.delete();
        for (int i = 0; i < 4; i++) push(i, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.we !== 1'b0 || bus.data !== '0 || bus.word_idx !== '0 || bus.pix_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_outputs: got we=%b idx=%0d ready=%b data=%h expected 0 0 1 0",
                     bus.we, bus.word_idx, bus.pix_ready, bus.data);
        end
        @(posedge clk);
        #1;
        // Held word discarded by reset while stalled.
        for (int i = 0; i < 10; i++) push(300 + i, 1'b0);
        bus.out_stall = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus.we !== 1'b0 || bus.pix_ready !== 1'b1 || bus.data !== '0) begin
            n_fail++;
            $display("FAIL pendreset_outputs: got we=%b ready=%b data=%h expected 0 1 0", bus.we, bus.pix_ready, bus.data);
        end
        @(posedge clk);
        #1 bus.out_stall = 1'b0;
        for (int i = 0; i < 10; i++) push(50 + i, 1'b0);
        idle(3);
        n_checks++;
        if (q.size() != 1) begin
            n_fail++; $display("FAIL midreset_count: got %0d writes expected 1", q.size());
        end else begin
            n_checks++;
            if (q[0].idx !== '0 || q[0].data !== mkword(50, 10)) begin
                n_fail++;
                $display("FAIL midreset_word: got idx=%0d data=%h expected idx=0 data=%h", q[0].idx, q[0].data, mkword(50, 10));
            end
        end
    endtask

    initial begin
        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst           = 1'b1;
        bus.pix_valid = 1'b0;
        bus.pix_last  = 1'b0;
        bus.pix_in    = '0;
        bus.out_stall = 1'b0;
        test_reset();
        test_clean_frame();
        test_early_last();
        test_missing_last();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_word();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
